// File: rtl/pc_unit.sv
// Program counter with branch/jump/call/return selection, sticky halt and a
// circular return-address stack that overwrites its oldest entry when full.
module pc_unit #(
    parameter int                WORD_W    = 32,
    parameter logic [WORD_W-1:0] PC_RESET  = '0,
    parameter int                PC_STEP   = 4,
    parameter int                RAS_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         pc_en,
    input  logic                         halt,
    input  logic                         br_taken,
    input  logic [WORD_W-1:0]            br_target,
    input  logic                         jmp,
    input  logic                         call,
    input  logic [WORD_W-1:0]            jmp_target,
    input  logic                         ret,
    output logic [WORD_W-1:0]            pc,
    output logic [WORD_W-1:0]            next_pc,
    output logic                         halted,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [WORD_W-1:0] ALIGN_MASK = ~(WORD_W'(PC_STEP) - WORD_W'(1));

    logic [WORD_W-1:0] ras_mem [RAS_DEPTH];
    // wr_ptr is the slot the next push writes; the top entry sits one below it.
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  top_idx;
    logic [WORD_W-1:0] seq;
    logic [WORD_W-1:0] ras_top;
    logic              do_push;
    logic              do_pop;
    logic              do_replace;
    logic              set_halt;
    logic              set_uflow;

    assign seq     = pc + WORD_W'(PC_STEP);
    assign top_idx = wr_ptr - PTR_W'(1);
    assign ras_top = ras_mem[top_idx];

    always_comb begin
        next_pc    = pc;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_replace = 1'b0;
        set_halt   = 1'b0;
        set_uflow  = 1'b0;
        if (pc_en && !halted) begin
            if (halt) begin
                set_halt = 1'b1;
            end else if (br_taken) begin
                next_pc = br_target & ALIGN_MASK;
            end else if (ret) begin
                next_pc = (ras_count != '0) ? ras_top : seq;
                if (call) begin
                    do_replace = 1'b1;
                end else if (ras_count != '0) begin
                    do_pop = 1'b1;
                end else begin
                    set_uflow = 1'b1;
                end
            end else if (call) begin
                next_pc = jmp_target & ALIGN_MASK;
                do_push = 1'b1;
            end else if (jmp) begin
                next_pc = jmp_target & ALIGN_MASK;
            end else begin
                next_pc = seq;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc            <= PC_RESET;
            halted        <= 1'b0;
            ras_count     <= '0;
            wr_ptr        <= '0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= next_pc;
            ras_underflow <= set_uflow;
            if (set_halt) begin
                halted <= 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (ras_count != CNT_W'(RAS_DEPTH)) begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end else if (do_pop) begin
                wr_ptr    <= top_idx;
                ras_count <= ras_count - CNT_W'(1);
            end else if (do_replace && ras_count == '0) begin
                ras_count <= CNT_W'(1);
            end
        end
    end

    // Storage is not reset; only pointer and count define which entries are valid.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            ras_mem[wr_ptr] <= seq;
        end else if (do_replace) begin
            ras_mem[top_idx] <= seq;
        end
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WORD_W, default 32: width of all PC and target values.
REQ-002 Parameter PC_RESET, default 0: PC value loaded on reset.
REQ-003 Parameter PC_STEP, default 4: sequential increment, a power of two, at least 1.
REQ-004 Parameter RAS_DEPTH, default 4: return-address stack entries, a power of two, at least 2.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-006 CLK  in  1  rising-edge clock.
REQ-007 nRST  in  1  asynchronous active-low reset.
REQ-008 pc_en  in  1  update enable; 0 means stall.
REQ-009 halt  in  1  halt request.
REQ-010 br_taken  in  1  branch resolved taken.
REQ-011 br_target  in  WORD_W  branch destination.
REQ-012 jmp  in  1  unconditional jump.
REQ-013 call  in  1  jump-and-link; implies a jump to jmp_target plus a RAS push.
REQ-014 jmp_target  in  WORD_W  jump/call destination.
REQ-015 ret  in  1  return; target is popped from the RAS.
REQ-016 pc  out  WORD_W  registered current PC.
REQ-017 next_pc  out  WORD_W  combinational value pc will take at the next edge.
REQ-018 halted  out  1  sticky halt flag.
REQ-019 ras_count  out  clog2(RAS_DEPTH)+1  number of valid RAS entries.
REQ-020 ras_underflow  out  1  registered one-cycle pulse.

Function
REQ-021 The block SHALL compute the sequential PC, seq, as (pc + PC_STEP) mod 2^WORD_W, so pc wraps silently from the top of the range to low values.
REQ-022 All targets SHALL have their low log2(PC_STEP) bits forced to 0 before use.
REQ-023 If pc_en=0 or halted=1, next_pc SHALL equal pc, the RAS and ras_count SHALL be unchanged, and ras_underflow SHALL be 0 on the next cycle.
REQ-024 Otherwise next_pc SHALL be chosen by fixed priority: halt, then br_taken, then ret, then call or jmp, then seq.
REQ-025 Halt case: next_pc=pc, halted set at the edge, no RAS change.
REQ-026 Branch case: next_pc=br_target; any call or ret on the same cycle SHALL be squashed, with no RAS change.
REQ-027 Ret case with ras_count>0: next_pc SHALL be the top entry and ras_count SHALL decrement.
REQ-028 Ret case with ras_count=0: next_pc SHALL be seq, ras_count SHALL stay 0, and ras_underflow SHALL be 1 for the following cycle.
REQ-029 Ret and call on the same cycle: next_pc SHALL be the popped top (or seq if empty), the top entry SHALL be overwritten with seq, and ras_count SHALL become max(ras_count,1).
REQ-030 Call case (without ret): next_pc=jmp_target, seq SHALL be pushed, and ras_count SHALL increment.
REQ-031 Call when ras_count=RAS_DEPTH: the oldest entry SHALL be overwritten (circular buffer) and ras_count SHALL stay at RAS_DEPTH.
REQ-032 Jmp case (without call or ret): next_pc=jmp_target, no RAS change.
REQ-033 pc SHALL register next_pc on every rising CLK edge; update latency is one cycle.
REQ-034 halted, once set, SHALL stay set until nRST.

Reset
REQ-035 While nRST=0, independent of CLK, the block SHALL hold pc=PC_RESET, halted=0, ras_count=0, and ras_underflow=0.
REQ-036 RAS storage contents SHALL NOT require reset; the pointer and count SHALL reset.
REQ-037 Reset asserted mid-operation SHALL take effect immediately.
REQ-038 The first edge after nRST rises SHALL apply the normal rules from pc=PC_RESET.

Verification (defaults WORD_W=32, PC_STEP=4, RAS_DEPTH=4, PC_RESET=0)
REQ-039 Sequential and stall: release reset, pc_en=1 for 3 cycles, then 0 for 2 -> pc goes 0,4,8,C, then holds at C.
REQ-040 Call/return: at pc=0x10, call with jmp_target=0x200 -> pc=0x200 and ras_count=1; ret -> pc=0x14 and ras_count=0.
REQ-041 Overflow and underflow: 5 calls from pcs 0x0,0x100,0x200,0x300,0x400 -> ras_count=4; 4 rets return 0x404,0x304,0x204,0x104; a 5th ret -> pc=seq and ras_underflow pulses for 1 cycle.
REQ-042 Priority: br_taken=1 (target 0x80), call=1, ret=1 in one cycle -> pc=0x80, ras_count unchanged; halt plus br_taken -> pc held, halted=1, later inputs ignored.
REQ-043 Wrap and alignment: pc=0xFFFFFFFC, pc_en=1 -> pc=0; jmp_target=0x103 -> pc=0x100.
REQ-044 Asynchronous reset: assert nRST low between edges with ras_count=2 and pc=0x300 -> pc=0 and ras_count=0 without waiting for CLK.
